// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: access width, FSM states and the held command.
package dmem_arbiter_pkg;

  localparam int unsigned CMD_AW_MAX  = 64;
  localparam int unsigned CMD_IDW_MAX = 8;

  typedef enum logic [1:0] {
    BW = 2'd0,
    HW = 2'd1,
    DW = 2'd2
  } data_width;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dmem_arb_state_t;

  // Command captured at the handshake; sized for the widest supported configuration.
  typedef struct packed {
    logic [CMD_IDW_MAX-1:0] id;
    logic                   rw;
    data_width              dw;
    logic [CMD_AW_MAX-1:0]  addr;
    logic [31:0]            wdata;
  } dmem_cmd_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational winner selection: strict-priority override, otherwise first valid after ptr.
module dmem_arbiter_rr_pick #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            hp_en,
  input  logic [IW-1:0]   hp_id,
  output logic [NREQ-1:0] grant_c,
  output logic [IW-1:0]   idx_c,
  output logic            any_c
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = '0;
    if (hp_en && (32'(hp_id) < NREQ) && req[hp_id]) begin
      any_c = 1'b1;
      idx_c = hp_id;
    end else begin
      // Scan from ptr+1 around to ptr itself so the last winner goes last.
      for (int unsigned i = 1; i <= NREQ; i++) begin
        cand = IW'((32'(ptr) + i) % NREQ);
        if (!any_c && req[cand]) begin
          any_c = 1'b1;
          idx_c = cand;
        end
      end
    end
    if (any_c) grant_c[idx_c] = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for the single-port data memory, one access outstanding.
// Optional DMEM_ARB_PERF_EN adds per-requester grant/wait counters and perf_clr.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ   = 2,
  parameter  int unsigned AW     = 32,
  parameter  int unsigned RD_LAT = 1,
  localparam int unsigned IW     = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_rw,
  input  data_width [NREQ-1:0]      req_dw,
  input  logic [NREQ-1:0][AW-1:0]   req_addr,
  input  logic [NREQ-1:0][31:0]     req_wdata,
  input  logic                      hp_en,
  input  logic [IW-1:0]             hp_id,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_rw,
  output data_width                 mem_dw,
  output logic [AW-1:0]             mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  input  logic                      perf_clr,
  output logic [NREQ-1:0][31:0]     perf_grant,
  output logic [NREQ-1:0][31:0]     perf_wait
`endif
);

  localparam int unsigned LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  dmem_arb_state_t state_q, state_d;
  dmem_cmd_t       cmd_q, cmd_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
  logic            mem_en_q, mem_en_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;

  logic [NREQ-1:0] pick_grant_c;
  logic [IW-1:0]   pick_idx_c;
  logic            pick_any_c;

  dmem_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .hp_en   (hp_en),
    .hp_id   (hp_id),
    .grant_c (pick_grant_c),
    .idx_c   (pick_idx_c),
    .any_c   (pick_any_c)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rr_ptr_d    = rr_ptr_q;
    lat_cnt_d   = lat_cnt_q;
    mem_en_d    = 1'b0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          // Ready is qualified by rst so nothing is accepted while reset is held.
          req_ready   = pick_grant_c & {NREQ{rst}};
          cmd_d.id    = CMD_IDW_MAX'(pick_idx_c);
          cmd_d.rw    = req_rw[pick_idx_c];
          cmd_d.dw    = req_dw[pick_idx_c];
          cmd_d.addr  = CMD_AW_MAX'(req_addr[pick_idx_c]);
          cmd_d.wdata = req_wdata[pick_idx_c];
          rr_ptr_d    = pick_idx_c;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_q.rw) begin
          rsp_valid_d = NREQ'(1) << cmd_q.id[IW-1:0];
          state_d     = RESP;
        end else begin
          lat_cnt_d = LW'(RD_LAT - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          rsp_rdata_d = mem_rdata;
          rsp_valid_d = NREQ'(1) << cmd_q.id[IW-1:0];
          state_d     = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - LW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rr_ptr_q    <= IW'(NREQ - 1);
      lat_cnt_q   <= '0;
      mem_en_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rr_ptr_q    <= rr_ptr_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_en_q    <= mem_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // mem_* come straight from the held command, so they keep their value between accesses.
  assign mem_en    = mem_en_q;
  assign mem_rw    = cmd_q.rw;
  assign mem_dw    = cmd_q.dw;
  assign mem_addr  = cmd_q.addr[AW-1:0];
  assign mem_wdata = cmd_q.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  if (AW < CMD_AW_MAX) begin : g_addr_pad
    logic unused_addr_hi;
    assign unused_addr_hi = ^cmd_q.addr[CMD_AW_MAX-1:AW];
  end
  if (IW < CMD_IDW_MAX) begin : g_id_pad
    logic unused_id_hi;
    assign unused_id_hi = ^cmd_q.id[CMD_IDW_MAX-1:IW];
  end

`ifdef DMEM_ARB_PERF_EN
  logic [NREQ-1:0][31:0] perf_grant_q, perf_grant_d;
  logic [NREQ-1:0][31:0] perf_wait_q, perf_wait_d;

  // Saturating handshake and stall counters.
  always_comb begin
    perf_grant_d = perf_grant_q;
    perf_wait_d  = perf_wait_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (perf_clr) begin
        perf_grant_d[i] = '0;
        perf_wait_d[i]  = '0;
      end else begin
        if (req_valid[i] && req_ready[i] && (perf_grant_q[i] != '1))
          perf_grant_d[i] = perf_grant_q[i] + 32'd1;
        if (req_valid[i] && !req_ready[i] && (perf_wait_q[i] != '1))
          perf_wait_d[i] = perf_wait_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_grant_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      perf_grant_q <= perf_grant_d;
      perf_wait_q  <= perf_wait_d;
    end
  end

  assign perf_grant = perf_grant_q;
  assign perf_wait  = perf_wait_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (NREQ=2, AW=32, RD_LAT=1).
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_rw;
  data_width [1:0]   req_dw;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic              hp_en;
  logic [0:0]        hp_id;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              mem_en;
  logic              mem_rw;
  data_width         mem_dw;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic              perf_clr;
  logic [1:0][31:0]  perf_grant;
  logic [1:0][31:0]  perf_wait;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.NREQ(2), .AW(32), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_dw    (req_dw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .hp_en     (hp_en),
    .hp_id     (hp_id),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_dw    (mem_dw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_clr   (perf_clr),
    .perf_grant (perf_grant),
    .perf_wait  (perf_wait)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid = 2'b00;
    req_rw    = 2'b00;
    req_dw    = {BW, BW};
    req_addr  = '0;
    req_wdata = '0;
    hp_en     = 1'b0;
    hp_id     = 1'b0;
    mem_rdata = '0;
`ifdef DMEM_ARB_PERF_EN
    perf_clr  = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic drain();
    req_valid = 2'b00;
    hp_en     = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    req_valid = 2'b11;
    tick();
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b exp 00", req_ready); end
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b exp 0", mem_en); end
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 00", rsp_valid); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
    n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h exp 0", mem_wdata); end
    n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h exp 0", rsp_rdata); end
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    req_valid    = 2'b01;
    req_rw[0]    = 1'b1;
    req_dw[0]    = DW;
    req_addr[0]  = 32'h0000_0100;
    req_wdata[0] = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_ready: got %b exp 01", req_ready); end
    tick();
    req_valid    = 2'b00;
    req_addr[0]  = 32'hFFFF_FFFF;
    req_wdata[0] = 32'h0;
    #1;
    n_tests++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL wr_mem_en: got %b exp 1", mem_en); end
    n_tests++; if (mem_rw !== 1'b1) begin n_fail++; $display("FAIL wr_mem_rw: got %b exp 1", mem_rw); end
    n_tests++; if (mem_dw !== DW) begin n_fail++; $display("FAIL wr_mem_dw: got %0d exp %0d", mem_dw, DW); end
    n_tests++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL wr_mem_addr: got %h exp 00000100", mem_addr); end
    n_tests++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_mem_wdata: got %h exp deadbeef", mem_wdata); end
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL wr_rsp_early: got %b exp 00", rsp_valid); end
    tick();
    n_tests++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL wr_rsp_valid: got %b exp 01", rsp_valid); end
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL wr_mem_en_drop: got %b exp 0", mem_en); end
    n_tests++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL wr_addr_hold: got %h exp 00000100", mem_addr); end
    tick();
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL wr_rsp_pulse: got %b exp 00", rsp_valid); end
  endtask

  task automatic test_read();
    int n_en;
    n_en = 0;
    req_valid   = 2'b01;
    req_rw[0]   = 1'b0;
    req_dw[0]   = HW;
    req_addr[0] = 32'h0000_0200;
    mem_rdata   = 32'hBAD0_BAD0;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rd_ready: got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    if (mem_en) n_en++;
    n_tests++; if (mem_rw !== 1'b0 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL rd_mem_cmd: got rw=%b addr=%h exp rw=0 addr=00000200", mem_rw, mem_addr); end
    tick();
    mem_rdata = 32'h1234_5678;
    if (mem_en) n_en++;
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rd_rsp_early: got %b exp 00", rsp_valid); end
    tick();
    mem_rdata = 32'hBAD0_BAD0;
    if (mem_en) n_en++;
    n_tests++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rd_rsp_valid: got %b exp 01", rsp_valid); end
    n_tests++; if (rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_rsp_rdata: got %h exp 12345678", rsp_rdata); end
    tick();
    if (mem_en) n_en++;
    n_tests++; if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_after: got valid=%b data=%h exp 00/12345678", rsp_valid, rsp_rdata); end
    n_tests++; if (n_en != 1) begin n_fail++; $display("FAIL rd_mem_en_cycles: got %0d exp 1", n_en); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    int got;
    do_reset();
    exp_g     = 2'b01;
    got       = 0;
    req_valid = 2'b11;
    req_rw    = 2'b11;
    #1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (req_ready !== 2'b00) begin
        n_tests++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d: got %b exp %b", got, req_ready, exp_g); end
        exp_g = {exp_g[0], exp_g[1]};
        got++;
      end
      tick();
    end
    n_tests++; if (got != 6) begin n_fail++; $display("FAIL rr_count: got %0d exp 6", got); end
    drain();
  endtask

  task automatic test_high_priority();
    logic [1:0] exp_g;
    int got;
    got       = 0;
    req_valid = 2'b11;
    req_rw    = 2'b11;
    hp_id     = 1'b1;
    for (int c = 0; c < 40 && got < 5; c++) begin
      hp_en = (got < 4);
      #1;
      exp_g = (got < 4) ? 2'b10 : 2'b01;
      if (req_ready !== 2'b00) begin
        n_tests++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL hp_grant%0d: got %b exp %b", got, req_ready, exp_g); end
        got++;
      end
      tick();
    end
    n_tests++; if (got != 5) begin n_fail++; $display("FAIL hp_count: got %0d exp 5", got); end
    drain();
  endtask

  task automatic test_withdraw();
    req_valid = 2'b01;
    req_rw    = 2'b11;
    tick();
    req_valid = 2'b10;
    #1;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL wd_busy_ready: got %b exp 00", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL wd_idle_ready: got %b exp 00", req_ready); end
    tick();
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL wd_mem_en: got %b exp 0", mem_en); end
  endtask

  task automatic test_reset_mid_access();
    req_valid = 2'b01;
    req_rw    = 2'b00;
    tick();
    req_valid = 2'b00;
    tick();
    req_valid = 2'b11;
    rst = 1'b0;
    #1;
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rm_mem_en: got %b exp 0", mem_en); end
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rm_ready: got %b exp 00", req_ready); end
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rm_rsp_valid: got %b exp 00", rsp_valid); end
    tick();
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rm_no_rsp: got %b exp 00", rsp_valid); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_cmd_clr: got %h exp 0", mem_addr); end
    rst = 1'b1;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_first_grant: got %b exp 01", req_ready); end
    drain();
  endtask

`ifdef DMEM_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    req_valid = 2'b01;
    req_rw    = 2'b11;
    hp_en     = 1'b1;
    hp_id     = 1'b0;
    tick();
    req_valid = 2'b11;
    repeat (5) tick();
    req_valid = 2'b10;
    hp_en     = 1'b0;
    #1;
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL perf_grant_req1: got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b00;
    n_tests++; if (perf_wait[1] !== 32'd5) begin n_fail++; $display("FAIL perf_wait1: got %0d exp 5", perf_wait[1]); end
    n_tests++; if (perf_grant[1] !== 32'd1) begin n_fail++; $display("FAIL perf_grant1: got %0d exp 1", perf_grant[1]); end
    n_tests++; if (perf_grant[0] !== 32'd2) begin n_fail++; $display("FAIL perf_grant0: got %0d exp 2", perf_grant[0]); end
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    n_tests++; if (perf_wait[1] !== 32'd0 || perf_grant[1] !== 32'd0) begin n_fail++; $display("FAIL perf_clr: got wait=%0d grant=%0d exp 0/0", perf_wait[1], perf_grant[1]); end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_round_robin();
    test_high_priority();
    test_withdraw();
    test_reset_mid_access();
`ifdef DMEM_ARB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
